// File: rtl/rv32i_types.sv
// Shared types and defaults for the burst-memory arbiter.
package rv32i_types;

  localparam int BMEM_BURST_LEN  = 4;
  localparam int BMEM_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } bmem_arb_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bmem_arbiter_rr_select.sv
// Round-robin picker: first requesting port strictly after last_i, wrapping.
module rr_select
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IW        = idx_bits(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IW-1:0]        last_i,
  output logic [IW-1:0]        grant_o,
  output logic                 valid_o
);

  // Scan ports last+1, last+2, ... last (the last granted port has lowest priority).
  always_comb begin
    int cand;
    cand    = 0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last_i) + i) % NUM_PORTS;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        grant_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates cacheline read/write requests from NUM_PORTS caches onto one
// burst memory. Optional per-port completion counters: BMEM_ARB_STATS_EN.
//
// Handshake: a port holds req_read/req_write as a level; once granted the
// burst runs to completion and req_resp[port] pulses for one cycle (DONE).
// On the memory side bmem_read/bmem_write stay high for the whole burst and
// every cycle with bmem_resp=1 is one accepted beat; bmem_resp is ignored
// outside a burst.
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int BURST_LEN  = BMEM_BURST_LEN,
  parameter int DATA_WIDTH = BMEM_DATA_WIDTH,
  parameter int LINE_W     = BURST_LEN * DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0][31:0]         req_address,
  input  logic [NUM_PORTS-1:0]               req_read,
  input  logic [NUM_PORTS-1:0]               req_write,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]                  req_rdata,
  output logic [NUM_PORTS-1:0]               req_resp,
  output logic [31:0]                        bmem_address,
  output logic                               bmem_read,
  output logic                               bmem_write,
  output logic [DATA_WIDTH-1:0]              bmem_wdata,
  input  logic [DATA_WIDTH-1:0]              bmem_rdata,
  input  logic                               bmem_resp,
`ifdef BMEM_ARB_STATS_EN
  output logic [NUM_PORTS-1:0][31:0]         grant_count,
`endif
  output bmem_arb_state_t                    dbg_state
);

  localparam int IW   = idx_bits(NUM_PORTS);
  localparam int BW   = idx_bits(BURST_LEN);
  localparam int OFFB = $clog2(LINE_W / 8);
  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << OFFB) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  bmem_arb_state_t state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;

  logic [IW-1:0] sel_idx;
  logic          sel_valid;

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_rr_select (
    .req_i   (req_read | req_write),
    .last_i  (rr_q),
    .grant_o (sel_idx),
    .valid_o (sel_valid)
  );

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      grant_q <= '0;
      rr_q    <= IW'(NUM_PORTS - 1);
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next-state: grant in IDLE, count accepted beats, one DONE cycle per burst.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          addr_d  = req_address[sel_idx] & ADDR_MASK;
          beat_d  = '0;
          // A write wins if a port raises both strobes.
          if (req_write[sel_idx]) begin
            wline_d = req_wdata[sel_idx];
            state_d = WR_BURST;
          end else begin
            state_d = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        if (bmem_resp) begin
          rline_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bmem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (bmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        rr_d    = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion pulse for the granted port during the DONE cycle only.
  always_comb begin
    req_resp = '0;
    if (state_q == DONE) req_resp[grant_q] = 1'b1;
  end

  assign bmem_read    = (state_q == RD_BURST);
  assign bmem_write   = (state_q == WR_BURST);
  assign bmem_address = addr_q;
  assign bmem_wdata   = wline_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
  assign req_rdata    = rline_q;
  assign dbg_state    = state_q;

`ifdef BMEM_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q;

  // Per-port completed-transaction counters, bumped once per DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == DONE) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: burst-memory responder with a line-level memory
// model, round-robin order model, directed scenarios then random traffic.
module tb_bmem_arbiter;
  import rv32i_types::*;

  localparam int N  = 2;
  localparam int BL = 4;
  localparam int DW = 64;
  localparam int LW = BL * DW;
  localparam logic [31:0] AMASK = 32'hFFFF_FFE0;

  logic                   clk;
  logic                   rst;
  logic [N-1:0][31:0]     req_address;
  logic [N-1:0]           req_read;
  logic [N-1:0]           req_write;
  logic [N-1:0][LW-1:0]   req_wdata;
  logic [LW-1:0]          req_rdata;
  logic [N-1:0]           req_resp;
  logic [31:0]            bmem_address;
  logic                   bmem_read;
  logic                   bmem_write;
  logic [DW-1:0]          bmem_wdata;
  logic [DW-1:0]          bmem_rdata;
  logic                   bmem_resp;
`ifdef BMEM_ARB_STATS_EN
  logic [N-1:0][31:0]     grant_count;
`endif
  bmem_arb_state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  // Memory model (line granularity) and responder state.
  logic [LW-1:0] mem_model [logic [31:0]];
  bit            in_burst;
  bit            b_wr;
  logic [31:0]   b_addr;
  int            rsp_beat;
  int            gap_cnt;
  int            gap_cfg;
  logic [LW-1:0] cur_line;
  logic [LW-1:0] wbuf;
  logic [31:0]   last_addr;
  bit            last_wr;

  // Requester-side model.
  bit            t_wr   [N];
  logic [31:0]   t_addr [N];
  logic [LW-1:0] t_line [N];
  int            done_cnt [N];
  int            rr_last;
  logic [LW-1:0] last_rd_line;
  logic [31:0]   pool [8];

  bmem_arbiter #(
    .NUM_PORTS  (N),
    .BURST_LEN  (BL),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_address  (req_address),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_rdata    (req_rdata),
    .req_resp     (req_resp),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
`ifdef BMEM_ARB_STATS_EN
    .grant_count  (grant_count),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int pick_gap();
    return (gap_cfg < 0) ? int'($urandom_range(0, 3)) : gap_cfg;
  endfunction

  // Round-robin rule: first pending port after the last one served.
  function automatic int next_rr(input logic [N-1:0] pending);
    for (int i = 1; i <= N; i++) begin
      if (pending[(rr_last + i) % N]) return (rr_last + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [LW-1:0] mem_get(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : '0;
  endfunction

  // Burst memory responder: beats in order, optional gaps, noise when idle.
  initial begin
    bmem_resp = 1'b0;
    bmem_rdata = '0;
    in_burst = 0;
    rsp_beat = 0;
    gap_cnt = 0;
    gap_cfg = 0;
    wbuf = '0;
    cur_line = '0;
    last_addr = '0;
    last_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bmem_resp = 1'b0;
        in_burst = 0;
        rsp_beat = 0;
        gap_cnt = 0;
      end else begin
        chk("rd_wr_exclusive", LW'(bmem_read && bmem_write), '0);
        if (!in_burst && (bmem_read || bmem_write)) begin
          in_burst = 1;
          b_wr = bmem_write;
          b_addr = bmem_address;
          rsp_beat = 0;
          gap_cnt = pick_gap();
          if (!b_wr) cur_line = mem_model.exists(b_addr) ? mem_model[b_addr] : rand_line();
        end
        if (in_burst) begin
          chk("burst_hold", LW'({bmem_read, bmem_write, bmem_address}), LW'({!b_wr, b_wr, b_addr}));
          if (gap_cnt > 0) begin
            bmem_resp = 1'b0;
            bmem_rdata = {$urandom, $urandom};
            gap_cnt--;
          end else begin
            bmem_resp = 1'b1;
            if (b_wr) wbuf[rsp_beat*DW +: DW] = bmem_wdata;
            else bmem_rdata = cur_line[rsp_beat*DW +: DW];
            rsp_beat++;
            gap_cnt = pick_gap();
            if (rsp_beat == BL) begin
              if (b_wr) mem_model[b_addr] = wbuf;
              last_addr = b_addr;
              last_wr = b_wr;
              in_burst = 0;
            end
          end
        end else begin
          bmem_resp = 1'($urandom_range(0, 1));
          bmem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bmem_read"}, LW'(bmem_read), '0);
    chk({tag, "_bmem_write"}, LW'(bmem_write), '0);
    chk({tag, "_req_resp"}, LW'(req_resp), '0);
    chk({tag, "_req_rdata"}, req_rdata, '0);
    chk({tag, "_bmem_address"}, LW'(bmem_address), '0);
    chk({tag, "_state"}, LW'(dbg_state), LW'(IDLE));
  endtask

  task automatic model_reset();
    rr_last = N - 1;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    last_rd_line = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst = 1'b0;
    req_read = '0;
    req_write = '0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Issue requests on the ports in act; check grant order and results.
  task automatic run_set(input logic [N-1:0] act, input bit drop);
    logic [N-1:0]  pending;
    logic [31:0]   a;
    logic [LW-1:0] exp_line;
    int cyc;
    int p;
    bit zero_next;
    @(negedge clk); #1;
    pending = act;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        req_address[i] = t_addr[i];
        req_wdata[i] = t_line[i];
        req_write[i] = t_wr[i];
        req_read[i] = !t_wr[i];
      end
    end
    cyc = 0;
    zero_next = 0;
    while ((pending != '0 || zero_next) && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (drop && (bmem_read || bmem_write)) begin
        req_read = '0;
        req_write = '0;
      end
      if (zero_next) begin
        chk("resp_one_cycle", LW'(req_resp), '0);
        zero_next = 0;
      end else if (req_resp != '0) begin
        p = next_rr(pending);
        chk("resp_port", LW'(req_resp), LW'(1 << p));
        a = t_addr[p] & AMASK;
        chk("burst_addr", LW'(last_addr), LW'(a));
        chk("burst_kind", LW'(last_wr), LW'(t_wr[p]));
        if (t_wr[p]) begin
          chk("wr_line", mem_get(a), t_line[p]);
          chk("rdata_hold", req_rdata, last_rd_line);
        end else begin
          exp_line = mem_get(a);
          chk("rd_line", req_rdata, exp_line);
          last_rd_line = exp_line;
        end
        req_read[p] = 1'b0;
        req_write[p] = 1'b0;
        pending[p] = 1'b0;
        rr_last = p;
        done_cnt[p]++;
        zero_next = 1;
      end
    end
    if (pending != '0) begin
      chk("txn_timeout", LW'(pending), '0);
      req_read = '0;
      req_write = '0;
    end
  endtask

  // Directed steps then random traffic.
  initial begin
    int cyc;
    logic [N-1:0] act;
    rst = 1'b0;
    req_address = '0;
    req_read = '0;
    req_write = '0;
    req_wdata = '0;
    model_reset();

    do_reset("reset");

    // Single read, fixed beats.
    mem_model[32'h0000_1040] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    gap_cfg = 0;
    t_wr[0] = 0; t_addr[0] = 32'h0000_1040;
    run_set(2'b01, 0);
    chk("single_read_const", req_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    // Unaligned address lands on the same line.
    t_addr[0] = 32'h0000_105B;
    run_set(2'b01, 0);

    // Contention out of reset: port 0 first, then port 1, twice.
    do_reset("reset2");
    mem_model[32'h0000_2000] = rand_line();
    mem_model[32'h0000_3000] = rand_line();
    t_wr[0] = 0; t_addr[0] = 32'h0000_2000;
    t_wr[1] = 0; t_addr[1] = 32'h0000_3000;
    run_set(2'b11, 0);
    run_set(2'b11, 0);

    // Port 1 write, then read it back on port 0.
    t_wr[1] = 1; t_addr[1] = 32'h0000_4000;
    t_line[1] = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_set(2'b10, 0);
    t_wr[0] = 0; t_addr[0] = 32'h0000_4000;
    run_set(2'b01, 0);
    chk("write_readback", req_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

    // Stalled memory, 3-cycle gaps.
    gap_cfg = 3;
    t_wr[0] = 0; t_addr[0] = 32'h0000_1040;
    run_set(2'b01, 0);
    // Request dropped once the burst has started; it still completes.
    gap_cfg = -1;
    t_wr[1] = 0; t_addr[1] = 32'h0000_3000;
    run_set(2'b10, 1);

    // Reset after two accepted beats.
    gap_cfg = 0;
    @(negedge clk); #1;
    req_address[0] = 32'h0000_2000;
    req_read[0] = 1'b1;
    cyc = 0;
    while (!(in_burst && rsp_beat == 2) && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("mid_burst_reached", LW'(cyc < 100), LW'(1'b1));
    @(posedge clk); #2;
    rst = 1'b0;
    req_read = '0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("midrst_no_resp", LW'(req_resp), '0);
    end
    t_wr[0] = 0; t_addr[0] = 32'h0000_2000;
    run_set(2'b01, 0);

    // Three port-0 reads and one port-1 write since reset.
    run_set(2'b01, 0);
    run_set(2'b01, 0);
    t_wr[1] = 1; t_addr[1] = 32'h0000_5000; t_line[1] = rand_line();
    run_set(2'b10, 0);
`ifdef BMEM_ARB_STATS_EN
    chk("grant_count_p0", LW'(grant_count[0]), LW'(32'd3));
    chk("grant_count_p1", LW'(grant_count[1]), LW'(32'd1));
`endif

    // Random traffic over a small preloaded address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'h0001_0000 + 32'(i) * 32'h100;
      mem_model[pool[i]] = rand_line();
    end
    gap_cfg = -1;
    for (int it = 0; it < 24; it++) begin
      act = N'($urandom_range(1, 3));
      for (int p = 0; p < N; p++) begin
        t_wr[p] = 1'($urandom_range(0, 1));
        t_addr[p] = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 31));
        t_line[p] = rand_line();
      end
      run_set(act, 0);
    end
`ifdef BMEM_ARB_STATS_EN
    for (int p = 0; p < N; p++) chk("grant_count", LW'(grant_count[p]), LW'(32'(done_cnt[p])));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
